// File: rtl/mmc1_write_sequencer.sv
// mmc1_write_sequencer: oversamples the CPU bus, qualifies M2 cycles and applies MMC1 serial-load rules,
// emitting one-clock commit and reset-request pulses for the register bank.
module mmc1_write_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_M2_HIGH = 2
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       CPU_M2,
  input  logic       nCPU_ROMSEL,
  input  logic       nCPU_RW,
  input  logic       CPU_A14,
  input  logic       CPU_A13,
  input  logic       CPU_D0,
  input  logic       CPU_D7,
  output logic       WR_VALID,
  output logic [1:0] WR_SEL,
  output logic [4:0] WR_DATA,
  output logic       RESET_REQ,
  output logic [2:0] SHIFT_CNT,
  output logic       BUSY
);
  typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0][6:0] sync_q;
  logic [6:0] s;
  logic       m2;
  logic [5:0] cap, cap_n;
  logic [3:0] high_cnt, high_n;
  logic [4:0] shift, shift_n, data_n;
  logic [2:0] cnt_n;
  logic [1:0] sel_n;
  logic       prev_wr, prev_n, valid_n, rreq_n, eval, cycle_ok, is_wr;
  assign s = sync_q[SYNC_STAGES-1];
  assign m2 = s[6];
  assign eval = (state == HIGH) && !m2;
  assign cycle_ok = high_cnt >= 4'(MIN_M2_HIGH);
  assign is_wr = !cap[5] && !cap[4];
  assign BUSY = SHIFT_CNT != 3'd0;
  // Synchronizer resets to all-ones so an M2 high in progress at reset release reads as high and is skipped.
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) sync_q <= '1;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], {CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7}};
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      state     <= WAIT_LOW;
      high_cnt  <= '0;
      cap       <= '0;
      shift     <= '0;
      prev_wr   <= 1'b0;
      SHIFT_CNT <= '0;
      WR_VALID  <= 1'b0;
      RESET_REQ <= 1'b0;
      WR_SEL    <= '0;
      WR_DATA   <= '0;
    end else begin
      state     <= state_n;
      high_cnt  <= high_n;
      cap       <= cap_n;
      shift     <= shift_n;
      prev_wr   <= prev_n;
      SHIFT_CNT <= cnt_n;
      WR_VALID  <= valid_n;
      RESET_REQ <= rreq_n;
      WR_SEL    <= sel_n;
      WR_DATA   <= data_n;
    end
  always_comb begin
    state_n = state;
    high_n  = high_cnt;
    cap_n   = cap;
    shift_n = shift;
    cnt_n   = SHIFT_CNT;
    prev_n  = prev_wr;
    valid_n = 1'b0;
    rreq_n  = 1'b0;
    sel_n   = WR_SEL;
    data_n  = WR_DATA;
    unique case (state)
      WAIT_LOW: state_n = m2 ? WAIT_LOW : IDLE;
      IDLE: if (m2) begin
        state_n = HIGH;
        high_n  = 4'd1;
        cap_n   = s[5:0];
      end
      HIGH: if (m2) begin
        high_n = cycle_ok ? high_cnt : high_cnt + 4'd1;
        cap_n  = s[5:0];
      end else state_n = IDLE;
      default: state_n = WAIT_LOW;
    endcase
    // cap = {nROMSEL, nRW, A14, A13, D0, D7} from the last M2-high sample
    if (eval && cycle_ok) begin
      prev_n = is_wr;
      if (is_wr && !prev_wr) begin
        if (cap[0]) begin
          shift_n = '0;
          cnt_n   = '0;
          rreq_n  = 1'b1;
        end else if (SHIFT_CNT != 3'd4) begin
          shift_n = {cap[1], shift[4:1]};
          cnt_n   = SHIFT_CNT + 3'd1;
        end else begin
          data_n  = {cap[1], shift[4:1]};
          sel_n   = cap[3:2];
          valid_n = 1'b1;
          shift_n = '0;
          cnt_n   = '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mmc1_write_sequencer.sv
// tb_mmc1_write_sequencer: table-driven CPU cycles with a scoreboard of expected commit/reset pulses.
module tb_mmc1_write_sequencer;
  logic clk = 1'b0, n_reset = 1'b0;
  logic m2 = 1'b0, romsel_n = 1'b1, rw_n = 1'b1, a14 = 1'b0, a13 = 1'b0, d0 = 1'b0, d7 = 1'b0;
  logic wr_valid, reset_req, busy;
  logic [1:0] wr_sel;
  logic [4:0] wr_data;
  logic [2:0] shift_cnt;
  int checks = 0, errors = 0;
  typedef struct {
    int h; logic rom; logic rw; logic [1:0] a; logic d0; logic d7;
    logic [2:0] cnt; int ev; logic [4:0] data;
  } vec_t;
  typedef struct { int ev; logic [1:0] sel; logic [4:0] data; } exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  logic [1:0] last_sel = '0;
  logic [4:0] last_data = '0;
  logic prev_valid = 1'b0, prev_rreq = 1'b0;

  mmc1_write_sequencer #(.SYNC_STAGES(2), .MIN_M2_HIGH(2)) dut (
    .CLK(clk), .nRESET(n_reset), .CPU_M2(m2), .nCPU_ROMSEL(romsel_n), .nCPU_RW(rw_n),
    .CPU_A14(a14), .CPU_A13(a13), .CPU_D0(d0), .CPU_D7(d7),
    .WR_VALID(wr_valid), .WR_SEL(wr_sel), .WR_DATA(wr_data), .RESET_REQ(reset_req),
    .SHIFT_CNT(shift_cnt), .BUSY(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int h, logic rom, logic rw, logic [1:0] a, logic dd0, logic dd7,
                              logic [2:0] cnt, int ev, logic [4:0] data);
    return '{h, rom, rw, a, dd0, dd7, cnt, ev, data};
  endfunction
  function automatic vec_t wr(logic [1:0] a, logic dd0, logic [2:0] cnt);
    return mk(4, 0, 0, a, dd0, 0, cnt, 0, 0);
  endfunction
  function automatic vec_t rd(logic [2:0] cnt);
    return mk(4, 0, 1, 0, 0, 0, cnt, 0, 0);
  endfunction
  function automatic vec_t rs(logic [2:0] cnt, int ev);
    return mk(4, 0, 0, 0, 0, 1, cnt, ev, 0);
  endfunction
  function automatic vec_t cm(logic [1:0] a, logic dd0, logic [4:0] data);
    return mk(4, 0, 0, a, dd0, 0, 0, 1, data);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    if (v.ev == 1) begin
      sb.push_back('{1, v.a, v.data});
      last_sel = v.a;
      last_data = v.data;
    end else if (v.ev == 2) sb.push_back('{2, last_sel, last_data});
    @(negedge clk);
    {romsel_n, rw_n, a14, a13, d0, d7} = {v.rom, v.rw, v.a, v.d0, v.d7};
    m2 = 1'b1;
    repeat (v.h) @(negedge clk);
    m2 = 1'b0;
    repeat (5) @(negedge clk);
    check("shift_cnt", int'(shift_cnt), int'(v.cnt));
    check("busy", int'(busy), int'(v.cnt != 0));
  endtask

  // Pulse monitor: every WR_VALID / RESET_REQ must match the next scoreboard entry and last one clock.
  always @(negedge clk) begin
    if (n_reset && (wr_valid || reset_req)) begin
      checks++;
      if ((wr_valid && reset_req) || (wr_valid && prev_valid) || (reset_req && prev_rreq)) begin
        errors++;
        $display("FAIL pulse_shape: valid=%0b reset_req=%0b prev_valid=%0b prev_rreq=%0b",
                 wr_valid, reset_req, prev_valid, prev_rreq);
      end
      if (!prev_valid && !prev_rreq) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: valid=%0b reset_req=%0b sel=%0d data=%b",
                   wr_valid, reset_req, wr_sel, wr_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checks++;
          if (wr_valid != (e.ev == 1) || reset_req != (e.ev == 2) || wr_sel != e.sel || wr_data != e.data) begin
            errors++;
            $display("FAIL event: got valid=%0b reset_req=%0b sel=%0d data=%b expected kind=%0d sel=%0d data=%b",
                     wr_valid, reset_req, wr_sel, wr_data, e.ev, e.sel, e.data);
          end
        end
      end
    end
    prev_valid <= wr_valid;
    prev_rreq <= reset_req;
  end

  initial begin
    // five writes to $E000 interleaved with reads
    vecs = '{wr(3,1,1), rd(1), wr(3,0,2), rd(2), wr(3,1,3), rd(3), wr(3,1,4), rd(4), cm(3,0,5'b01101), rd(0)};
    // partial load, D7 reset, then full load to $8000
    vecs = {vecs, wr(0,1,1), rd(1), wr(0,1,2), rd(2), wr(0,1,3), rd(3), rs(0,2), rd(0),
            wr(0,0,1), rd(1), wr(0,0,2), rd(2), wr(0,1,3), rd(3), wr(0,1,4), rd(4), cm(0,1,5'b11100), rd(0)};
    // back-to-back writes: second one ignored
    vecs = {vecs, wr(3,1,1), wr(3,0,1), rd(1), wr(3,1,2), rd(2), rs(0,2), rd(0)};
    // D7 write right after a write is ignored
    vecs = {vecs, wr(3,1,1), rs(1,0), rd(1)};
    // 1-CLK M2 glitch between writes is ignored
    vecs = {vecs, wr(3,1,2), rd(2), mk(1,0,0,3,0,0,2,0,0), wr(3,1,3), rd(3), rs(0,2), rd(0)};
    // build up three bits before the mid-sequence reset
    vecs = {vecs, wr(1,1,1), rd(1), wr(1,0,2), rd(2), wr(1,1,3), rd(3)};

    repeat (3) @(negedge clk);
    check("rst_wr_valid", int'(wr_valid), 0);
    check("rst_reset_req", int'(reset_req), 0);
    check("rst_wr_sel", int'(wr_sel), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_shift_cnt", int'(shift_cnt), 0);
    check("rst_busy", int'(busy), 0);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) apply(vecs[i]);

    // reset pulsed while M2 high with SHIFT_CNT=3
    @(negedge clk);
    {romsel_n, rw_n, a14, a13, d0, d7} = 6'b00_11_1_0;
    m2 = 1'b1;
    repeat (3) @(negedge clk);
    n_reset = 1'b0;
    #1;
    check("mid_rst_outputs", int'({wr_valid, reset_req, wr_sel, wr_data, shift_cnt, busy}), 0);
    last_sel = '0;
    last_data = '0;
    @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    m2 = 1'b0;
    repeat (5) @(negedge clk);
    check("after_rst_shift_cnt", int'(shift_cnt), 0);
    check("after_rst_wr_data", int'(wr_data), 0);
    apply(wr(1,0,1)); apply(rd(1)); apply(wr(1,1,2)); apply(rd(2));
    apply(wr(1,0,3)); apply(rd(3)); apply(wr(1,1,4)); apply(rd(4));
    apply(cm(1,1,5'b11010)); apply(rd(0));

    repeat (4) @(negedge clk);
    check("pending_events", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
